// File: rtl/lamp_pkg.sv
// Shared definitions for the staircase lamp controller.
//   lamp_state_e : FSM state encoding, also driven out on the debug state port
//   odd_parity   : three-way switch function (lamp follows odd parity)
package lamp_pkg;

  // OFF/ON/WARN encoding is visible on the debug port, so keep it fixed
  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_ON   = 2'b01,
    ST_WARN = 2'b10
  } lamp_state_e;

  localparam int unsigned NUM_SWITCHES = 3;

  // Any single switch flip changes the result, which is what makes it three-way
  function automatic logic odd_parity(input logic [NUM_SWITCHES-1:0] sw);
    return ^sw;
  endfunction

endpackage

// File: rtl/lamp_timer_ctrl_switch_debounce.sv
// Two-flop synchroniser followed by a stability debouncer for one raw switch.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   sw_i  in  raw switch level, asynchronous to clk, may bounce
//   sw_o  out debounced level, registered
module switch_debounce
  import lamp_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic sw_o
);

  // Sized to hold DEB_CYCLES-1 even when DEB_CYCLES is 1
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Metastability guard: only sync2_q is used downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive mismatching edges; the last one of DEB_CYCLES commits the new level.
  // The count stops at DEB_CYCLES-1 because that edge also clears it.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign sw_o = deb_q;

endmodule

// File: rtl/lamp_timer_ctrl.sv
// Staircase lamp controller: debounces three switches, turns the lamp on/off on every
// change of their odd parity, switches it off automatically after ON_CYCLES, and drives
// a buzzer with a confirmation beep per toggle plus a warning pattern before auto-off.
// Ports:
//   clk     in  system clock, rising edge
//   rst     in  asynchronous active-high reset
//   S1..S3  in  raw switches, asynchronous, may bounce
//   F       out lamp drive, registered
//   Buzzer  out buzzer drive, registered
//   state   out [1:0] FSM state for debug (OFF=00, ON=01, WARN=10)
module lamp_timer_ctrl
  import lamp_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned ON_CYCLES   = 1000,
  parameter int unsigned WARN_CYCLES = 100,
  parameter int unsigned BEEP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  output logic       F,
  output logic       Buzzer,
  output logic [1:0] state
);

  localparam int unsigned TIMER_W = $clog2(ON_CYCLES);
  localparam int unsigned BEEP_W  = $clog2(BEEP_CYCLES + 1);

  logic [NUM_SWITCHES-1:0] sw_raw;
  logic [NUM_SWITCHES-1:0] sw_deb;

  lamp_state_e        state_q;
  lamp_state_e        state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic [BEEP_W-1:0]  beep_cnt_q;
  logic [BEEP_W-1:0]  beep_cnt_d;
  logic [BEEP_W-1:0]  warn_cnt_q;
  logic [BEEP_W-1:0]  warn_cnt_d;
  logic               warn_phase_q;
  logic               warn_phase_d;
  logic               parity_q;
  logic               parity_c;
  logic               toggle_c;
  logic               f_q;
  logic               f_d;
  logic               buzzer_q;
  logic               buzzer_d;

  assign sw_raw = {S3, S2, S1};

  // One synchroniser/debouncer per switch
  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
    switch_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_switch_debounce (
      .clk (clk),
      .rst (rst),
      .sw_i(sw_raw[i]),
      .sw_o(sw_deb[i])
    );
  end

  // A toggle is any change of debounced parity; simultaneous flips cancel out
  assign parity_c = odd_parity(sw_deb);
  assign toggle_c = (parity_c != parity_q);

  // Next state, timer, beep and warning pattern
  always_comb begin
    state_d      = state_q;
    timer_d      = (timer_q != '0) ? timer_q - TIMER_W'(1) : '0;
    beep_cnt_d   = (beep_cnt_q != '0) ? beep_cnt_q - BEEP_W'(1) : '0;
    warn_cnt_d   = '0;
    warn_phase_d = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        if (toggle_c) begin
          state_d = ST_ON;
          timer_d = TIMER_W'(ON_CYCLES - 1);
        end
      end
      ST_ON: begin
        if (toggle_c) begin
          state_d = ST_OFF;
        end else if (timer_q == TIMER_W'(WARN_CYCLES)) begin
          state_d = ST_WARN;
        end
      end
      ST_WARN: begin
        if (toggle_c) begin
          state_d = ST_OFF;
        end else if (timer_q == '0) begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    // Every accepted toggle restarts the confirmation beep
    if (toggle_c) begin
      beep_cnt_d = BEEP_W'(BEEP_CYCLES);
    end

    // Warning pattern: starts high on entry, flips every BEEP_CYCLES cycles
    if (state_d == ST_WARN) begin
      if (state_q != ST_WARN) begin
        warn_phase_d = 1'b1;
        warn_cnt_d   = BEEP_W'(BEEP_CYCLES - 1);
      end else if (warn_cnt_q == '0) begin
        warn_phase_d = ~warn_phase_q;
        warn_cnt_d   = BEEP_W'(BEEP_CYCLES - 1);
      end else begin
        warn_phase_d = warn_phase_q;
        warn_cnt_d   = warn_cnt_q - BEEP_W'(1);
      end
    end

    f_d      = (state_d != ST_OFF);
    buzzer_d = (beep_cnt_d != '0) | ((state_d == ST_WARN) & warn_phase_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_OFF;
      timer_q      <= '0;
      beep_cnt_q   <= '0;
      warn_cnt_q   <= '0;
      warn_phase_q <= 1'b0;
      parity_q     <= 1'b0;
      f_q          <= 1'b0;
      buzzer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      beep_cnt_q   <= beep_cnt_d;
      warn_cnt_q   <= warn_cnt_d;
      warn_phase_q <= warn_phase_d;
      parity_q     <= parity_c;
      f_q          <= f_d;
      buzzer_q     <= buzzer_d;
    end
  end

  assign F      = f_q;
  assign Buzzer = buzzer_q;
  assign state  = state_q;

endmodule

// File: tb/tb_lamp_timer_ctrl.sv
// Directed bench for lamp_timer_ctrl with DEB=4, ON=40, WARN=10, BEEP=3.
module tb_lamp_timer_ctrl;

  localparam logic [1:0] S_OFF  = 2'b00;
  localparam logic [1:0] S_ON   = 2'b01;
  localparam logic [1:0] S_WARN = 2'b10;

  logic       clk;
  logic       rst;
  logic       S1;
  logic       S2;
  logic       S3;
  logic       F;
  logic       Buzzer;
  logic [1:0] state;

  int n_tests;
  int n_fail;

  lamp_timer_ctrl #(
    .DEB_CYCLES (4),
    .ON_CYCLES  (40),
    .WARN_CYCLES(10),
    .BEEP_CYCLES(3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .S1    (S1),
    .S2    (S2),
    .S3    (S3),
    .F     (F),
    .Buzzer(Buzzer),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1ns after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    S1 = 1'b0;
    S2 = 1'b0;
    S3 = 1'b0;
    #1;
    check("rst_f", 32'(F), 32'd0);
    check("rst_buz", 32'(Buzzer), 32'd0);
    check("rst_state", 32'(state), 32'(S_OFF));
    tick(2);
    rst = 1'b0;
    tick(3);

    // 1: S1 rises, lamp on at edge 7 with a 3-cycle beep
    S1 = 1'b1;
    tick(6);
    check("t1_f_edge6", 32'(F), 32'd0);
    tick(1);
    check("t1_f_edge7", 32'(F), 32'd1);
    check("t1_state_on", 32'(state), 32'(S_ON));
    check("t1_buz_edge7", 32'(Buzzer), 32'd1);
    tick(2);
    check("t1_buz_edge9", 32'(Buzzer), 32'd1);
    tick(1);
    check("t1_buz_edge10", 32'(Buzzer), 32'd0);

    // 2: auto-off sequence, relative to turn-on edge T
    tick(26);
    check("t2_on_T29", 32'(state), 32'(S_ON));
    tick(1);
    check("t2_warn_T30", 32'(state), 32'(S_WARN));
    check("t2_f_T30", 32'(F), 32'd1);
    check("t2_buz_T30", 32'(Buzzer), 32'd1);
    tick(2);
    check("t2_buz_T32", 32'(Buzzer), 32'd1);
    tick(1);
    check("t2_buz_T33", 32'(Buzzer), 32'd0);
    tick(2);
    check("t2_buz_T35", 32'(Buzzer), 32'd0);
    tick(1);
    check("t2_buz_T36", 32'(Buzzer), 32'd1);
    tick(3);
    check("t2_f_T39", 32'(F), 32'd1);
    check("t2_state_T39", 32'(state), 32'(S_WARN));
    check("t2_buz_T39", 32'(Buzzer), 32'd0);
    tick(1);
    check("t2_f_T40", 32'(F), 32'd0);
    check("t2_state_T40", 32'(state), 32'(S_OFF));
    check("t2_buz_T40", 32'(Buzzer), 32'd0);

    // 3: 2-cycle glitch on S2 must be ignored
    S2 = 1'b1;
    tick(2);
    S2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t3_f", 32'(F), 32'd0);
      check("t3_buz", 32'(Buzzer), 32'd0);
    end
    check("t3_state", 32'(state), 32'(S_OFF));

    // 4: S1 and S2 flip together, parity unchanged
    S1 = 1'b0;
    S2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("t4_f", 32'(F), 32'd0);
      check("t4_buz", 32'(Buzzer), 32'd0);
    end
    check("t4_state", 32'(state), 32'(S_OFF));

    // 5: turn on via S3, reach WARN, toggle off, toggle on again
    S3 = 1'b1;
    tick(7);
    check("t5_on", 32'(state), 32'(S_ON));
    tick(30);
    check("t5_warn", 32'(state), 32'(S_WARN));
    S3 = 1'b0;
    tick(6);
    check("t5_warn_hold", 32'(state), 32'(S_WARN));
    tick(1);
    check("t5_off_f", 32'(F), 32'd0);
    check("t5_off_state", 32'(state), 32'(S_OFF));
    check("t5_off_buz", 32'(Buzzer), 32'd1);
    tick(2);
    check("t5_off_buz_end", 32'(Buzzer), 32'd1);
    tick(1);
    check("t5_off_buz_done", 32'(Buzzer), 32'd0);
    S3 = 1'b1;
    tick(7);
    check("t5_reon_f", 32'(F), 32'd1);
    check("t5_reon_state", 32'(state), 32'(S_ON));
    check("t5_reon_buz", 32'(Buzzer), 32'd1);
    tick(29);
    check("t5_reon_T29", 32'(state), 32'(S_ON));
    tick(1);
    check("t5_reon_T30", 32'(state), 32'(S_WARN));

    // 6: reset mid-beep while ON, odd parity after release turns lamp on
    S3 = 1'b0;
    tick(7);
    check("t6_pre_off", 32'(state), 32'(S_OFF));
    S3 = 1'b1;
    tick(7);
    check("t6_pre_on", 32'(state), 32'(S_ON));
    tick(1);
    check("t6_pre_buz", 32'(Buzzer), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_f", 32'(F), 32'd0);
    check("t6_rst_buz", 32'(Buzzer), 32'd0);
    check("t6_rst_state", 32'(state), 32'(S_OFF));
    S1 = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    check("t6_rel_edge6", 32'(F), 32'd0);
    tick(1);
    check("t6_rel_f", 32'(F), 32'd1);
    check("t6_rel_state", 32'(state), 32'(S_ON));
    check("t6_rel_buz", 32'(Buzzer), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
